// File: rtl/mem_request_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_core_if / mem_arb_if
// Purpose  : core-side command bus and arbitrator-side request bus of the
//            per-core memory request unit.
// Revision : 1.0  initial release
// ============================================================================

// Core pipeline <-> request unit. The core is the master.
interface mem_core_if #(
  parameter int REG_SIZE     = 8,
  parameter int BANK_ID_SIZE = 4
);
  localparam int ADDR_SIZE = BANK_ID_SIZE + REG_SIZE;

  logic                 core_valid;
  logic [1:0]           core_op;
  logic [ADDR_SIZE-1:0] core_addr;
  logic [REG_SIZE-1:0]  core_wr_data;
  logic                 core_stall;
  logic                 core_rd_valid;
  logic [REG_SIZE-1:0]  core_rd_data;

  modport master (
    output core_valid, core_op, core_addr, core_wr_data,
    input  core_stall, core_rd_valid, core_rd_data
  );

  modport slave (
    input  core_valid, core_op, core_addr, core_wr_data,
    output core_stall, core_rd_valid, core_rd_data
  );
endinterface

// Request unit <-> banked-memory arbitrator slice. The request unit is the master.
interface mem_arb_if #(
  parameter int REG_SIZE     = 8,
  parameter int BANK_ID_SIZE = 4
);
  localparam int ADDR_SIZE = BANK_ID_SIZE + REG_SIZE;

  logic [1:0]           enable;
  logic [ADDR_SIZE-1:0] addr;
  logic [REG_SIZE-1:0]  wr_data;
  logic                 ready;
  logic [REG_SIZE-1:0]  rd_data;

  modport master (
    output enable, addr, wr_data,
    input  ready, rd_data
  );

  modport slave (
    input  enable, addr, wr_data,
    output ready, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/mem_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_unit
// Purpose  : per-core in-order load/store queue feeding one arbitrator slice.
//            Optional watchdog compiled in with MEM_REQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_request_unit #(
  parameter int REG_SIZE       = 8,
  parameter int BANK_ID_SIZE   = 4,
  parameter int FIFO_DEPTH     = 4
`ifdef MEM_REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic      clk,
  input  logic      reset,
  mem_core_if.slave core,
  mem_arb_if.master arb,
  output logic      idle,
  output logic      timeout_err
);

  localparam int ADDR_SIZE = BANK_ID_SIZE + REG_SIZE;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ENTRY_W   = 1 + ADDR_SIZE + REG_SIZE;

  localparam logic [1:0]       c_op_read  = 2'b01;
  localparam logic [1:0]       c_op_write = 2'b10;
  localparam logic [1:0]       c_en_read  = 2'b01;
  localparam logic [1:0]       c_en_write = 2'b10;
  localparam logic [CNT_W-1:0] c_full     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Queue entry layout: {is_read, addr, wr_data}
  logic [ENTRY_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_rd_pending;

  logic [1:0]           r_enable;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [REG_SIZE-1:0]  r_wr_data;
  logic                 r_rd_valid;
  logic [REG_SIZE-1:0]  r_rd_data;

  logic                 w_legal;
  logic                 w_is_read_cmd;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_stall;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_load;
  logic [ENTRY_W-1:0]   w_push_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_head_is_read;
  logic [ADDR_SIZE-1:0] w_head_addr;
  logic [REG_SIZE-1:0]  w_head_data;

  assign w_is_read_cmd = (core.core_op == c_op_read);
  assign w_legal       = w_is_read_cmd || (core.core_op == c_op_write);
  assign w_full        = (r_count == c_full);
  assign w_empty       = (r_count == '0);
  // At most one load is ever outstanding, so the core blocks behind it.
  assign w_stall       = w_full || r_rd_pending;
  assign w_push        = core.core_valid && w_legal && !w_stall;
  assign w_push_entry  = {w_is_read_cmd, core.core_addr, core.core_wr_data};

  assign w_head         = r_fifo[r_rd_ptr];
  assign w_head_is_read = w_head[ENTRY_W-1];
  assign w_head_addr    = w_head[ENTRY_W-2 -: ADDR_SIZE];
  assign w_head_data    = w_head[REG_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The head stays in the queue while issued; it is popped only on ready.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (arb.ready) begin
          w_pop       = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // Ready here is the echo of a duplicate grant and is dropped.
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rd_pending <= 1'b0;
      r_enable     <= 2'b00;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_rd_valid <= 1'b0;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_push && w_is_read_cmd) begin
        r_rd_pending <= 1'b1;
      end else if (w_pop && w_head_is_read) begin
        r_rd_pending <= 1'b0;
      end

      if (w_load) begin
        r_enable  <= w_head_is_read ? c_en_read : c_en_write;
        r_addr    <= w_head_addr;
        r_wr_data <= w_head_data;
      end else if (w_pop) begin
        r_enable  <= 2'b00;
      end

      if (w_pop && w_head_is_read) begin
        r_rd_data  <= arb.rd_data;
        r_rd_valid <= 1'b1;
      end
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] c_tmo_max  = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // Watchdog only flags; the request keeps waiting for its ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else if (w_load) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ISSUE && !arb.ready) begin
      if (r_tmo_cnt != c_tmo_max) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (r_tmo_cnt == c_tmo_last) begin
        r_tmo_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_tmo_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign core.core_stall    = w_stall;
  assign core.core_rd_valid = r_rd_valid;
  assign core.core_rd_data  = r_rd_data;
  assign arb.enable         = r_enable;
  assign arb.addr           = r_addr;
  assign arb.wr_data        = r_wr_data;
  assign idle               = w_empty && (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_request_unit
// Purpose  : scoreboard bench for mem_request_unit (directed + random traffic).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_request_unit;

  localparam int REG_SIZE     = 8;
  localparam int BANK_ID_SIZE = 4;
  localparam int ADDR_SIZE    = BANK_ID_SIZE + REG_SIZE;
  localparam int FIFO_DEPTH   = 4;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 8;
`endif

  typedef struct packed {
    logic [1:0]           en;
    logic [ADDR_SIZE-1:0] a;
    logic [REG_SIZE-1:0]  d;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  logic idle;
  logic timeout_err;

  logic                auto_arb = 1'b0;
  logic                auto_ready = 1'b0;
  logic [REG_SIZE-1:0] auto_rd_data = '0;
  logic                man_ready = 1'b0;
  logic [REG_SIZE-1:0] man_rd_data = '0;

  req_t                exp_req_q [$];
  logic [REG_SIZE-1:0] exp_rd_q  [$];

  int n_checks = 0;
  int n_errors = 0;

  mem_core_if #(.REG_SIZE(REG_SIZE), .BANK_ID_SIZE(BANK_ID_SIZE)) core_bus ();
  mem_arb_if  #(.REG_SIZE(REG_SIZE), .BANK_ID_SIZE(BANK_ID_SIZE)) arb_bus ();

  assign arb_bus.ready   = auto_arb ? auto_ready   : man_ready;
  assign arb_bus.rd_data = auto_arb ? auto_rd_data : man_rd_data;

  mem_request_unit #(
    .REG_SIZE      (REG_SIZE),
    .BANK_ID_SIZE  (BANK_ID_SIZE),
    .FIFO_DEPTH    (FIFO_DEPTH)
`ifdef MEM_REQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core       (core_bus),
    .arb        (arb_bus),
    .idle       (idle),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a free slot, drives one command for one cycle and records its expected request.
  task automatic issue_cmd(input logic [1:0] op, input logic [ADDR_SIZE-1:0] a,
                           input logic [REG_SIZE-1:0] d);
    int n = 0;
    while (core_bus.core_stall && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("stall_release", {31'b0, core_bus.core_stall}, 32'd0);
    core_bus.core_valid   = 1'b1;
    core_bus.core_op      = op;
    core_bus.core_addr    = a;
    core_bus.core_wr_data = d;
    exp_req_q.push_back('{en: op, a: a, d: d});
    @(negedge clk);
    core_bus.core_valid = 1'b0;
  endtask

  task automatic wait_enable();
    int n = 0;
    while (arb_bus.enable == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("enable_wait", {31'b0, arb_bus.enable != 2'b00}, 32'd1);
  endtask

  // Monitor: every new request and every load return is matched against the scoreboard.
  initial begin
    logic [1:0] prev_en;
    req_t       r;
    prev_en = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_en = 2'b00;
      end else begin
        if (arb_bus.enable != 2'b00 && prev_en == 2'b00) begin
          if (exp_req_q.size() == 0) begin
            check("issue_unexpected", {30'b0, arb_bus.enable}, 32'd0);
          end else begin
            r = exp_req_q.pop_front();
            check("issue_en", {30'b0, arb_bus.enable}, {30'b0, r.en});
            check("issue_addr", {20'b0, arb_bus.addr}, {20'b0, r.a});
            if (r.en == 2'b10) check("issue_wr_data", {24'b0, arb_bus.wr_data}, {24'b0, r.d});
          end
        end
        if (core_bus.core_rd_valid) begin
          if (exp_rd_q.size() == 0)
            check("rd_valid_spurious", {31'b0, core_bus.core_rd_valid}, 32'd0);
          else
            check("rd_data", {24'b0, core_bus.core_rd_data}, {24'b0, exp_rd_q.pop_front()});
        end
        prev_en = arb_bus.enable;
      end
    end
  end

  // Random-latency arbitrator model, also firing stray readies while no request is held.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(negedge clk);
      auto_ready = 1'b0;
      if (auto_arb && !reset) begin
        if (arb_bus.enable != 2'b00) begin
          if (hold == 0) hold = $urandom_range(1, 4);
          hold--;
          if (hold == 0) begin
            auto_ready   = 1'b1;
            auto_rd_data = REG_SIZE'($urandom_range(0, 255));
            if (arb_bus.enable == 2'b01) exp_rd_q.push_back(auto_rd_data);
          end
        end else begin
          hold         = 0;
          auto_ready   = ($urandom_range(0, 3) == 0);
          auto_rd_data = REG_SIZE'($urandom_range(0, 255));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] op;
    int         n;

    reset                 = 1'b1;
    core_bus.core_valid   = 1'b0;
    core_bus.core_op      = 2'b00;
    core_bus.core_addr    = '0;
    core_bus.core_wr_data = '0;
    tick(2);
    check("rst_enable", {30'b0, arb_bus.enable}, 32'd0);
    check("rst_idle", {31'b0, idle}, 32'd1);
    check("rst_stall", {31'b0, core_bus.core_stall}, 32'd0);
    check("rst_rd_valid", {31'b0, core_bus.core_rd_valid}, 32'd0);
    check("rst_rd_data", {24'b0, core_bus.core_rd_data}, 32'd0);
    check("rst_addr", {20'b0, arb_bus.addr}, 32'd0);
    check("rst_timeout", {31'b0, timeout_err}, 32'd0);
    reset = 1'b0;
    tick(1);

    // Single store
    issue_cmd(2'b10, 12'h305, 8'hA5);
    check("st_idle_low", {31'b0, idle}, 32'd0);
    check("st_en_not_yet", {30'b0, arb_bus.enable}, 32'd0);
    tick(1);
    check("st_en", {30'b0, arb_bus.enable}, 32'd2);
    check("st_addr", {20'b0, arb_bus.addr}, 32'h305);
    check("st_data", {24'b0, arb_bus.wr_data}, 32'hA5);
    tick(2);
    check("st_en_hold", {30'b0, arb_bus.enable}, 32'd2);
    man_ready = 1'b1;
    tick(1);
    man_ready = 1'b0;
    check("st_gap_en", {30'b0, arb_bus.enable}, 32'd0);
    check("st_gap_idle", {31'b0, idle}, 32'd0);
    tick(1);
    check("st_done_idle", {31'b0, idle}, 32'd1);

    // Single load with 4-cycle latency
    issue_cmd(2'b01, 12'h012, 8'h00);
    check("ld_stall_1", {31'b0, core_bus.core_stall}, 32'd1);
    tick(1);
    check("ld_en", {30'b0, arb_bus.enable}, 32'd1);
    check("ld_addr", {20'b0, arb_bus.addr}, 32'h012);
    check("ld_stall_2", {31'b0, core_bus.core_stall}, 32'd1);
    tick(1);
    check("ld_stall_3", {31'b0, core_bus.core_stall}, 32'd1);
    check("ld_rd_valid_early", {31'b0, core_bus.core_rd_valid}, 32'd0);
    man_ready   = 1'b1;
    man_rd_data = 8'h3C;
    exp_rd_q.push_back(8'h3C);
    tick(1);
    man_ready = 1'b0;
    check("ld_rd_valid", {31'b0, core_bus.core_rd_valid}, 32'd1);
    check("ld_rd_data", {24'b0, core_bus.core_rd_data}, 32'h3C);
    check("ld_stall_clear", {31'b0, core_bus.core_stall}, 32'd0);
    tick(1);
    check("ld_pulse_once", {31'b0, core_bus.core_rd_valid}, 32'd0);
    check("ld_data_held", {24'b0, core_bus.core_rd_data}, 32'h3C);
    check("ld_idle", {31'b0, idle}, 32'd1);

    // Illegal op is neither stalled nor queued
    core_bus.core_valid = 1'b1;
    core_bus.core_op    = 2'b11;
    tick(1);
    core_bus.core_valid = 1'b0;
    tick(2);
    check("ill_idle", {31'b0, idle}, 32'd1);
    check("ill_en", {30'b0, arb_bus.enable}, 32'd0);

    // Fill the queue, then drain with a ready also asserted in every GAP
    for (int i = 0; i < 4; i++) issue_cmd(2'b10, 12'h010 + 12'(i), 8'h10 + 8'(i));
    check("full_stall", {31'b0, core_bus.core_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_enable();
      check("drain_addr", {20'b0, arb_bus.addr}, 32'h10 + 32'(i));
      man_ready = 1'b1;
      tick(1);
      check("drain_gap_en", {30'b0, arb_bus.enable}, 32'd0);
      check("drain_gap_stall", {31'b0, core_bus.core_stall}, 32'd0);
      tick(1);
      man_ready = 1'b0;
    end
    tick(1);
    check("drain_idle", {31'b0, idle}, 32'd1);
    check("drain_q_empty", 32'(exp_req_q.size()), 32'd0);

    // Store then load: the load issues only after store ready plus GAP
    issue_cmd(2'b10, 12'h1A0, 8'h77);
    issue_cmd(2'b01, 12'h2B1, 8'h00);
    check("sl_store_first", {30'b0, arb_bus.enable}, 32'd2);
    man_ready = 1'b1;
    tick(1);
    man_ready = 1'b0;
    check("sl_gap", {30'b0, arb_bus.enable}, 32'd0);
    tick(1);
    check("sl_load_en", {30'b0, arb_bus.enable}, 32'd1);
    man_ready   = 1'b1;
    man_rd_data = 8'h5E;
    exp_rd_q.push_back(8'h5E);
    tick(1);
    man_ready = 1'b0;
    check("sl_rd_valid", {31'b0, core_bus.core_rd_valid}, 32'd1);
    tick(2);

    // Reset while a request is in flight with two more queued
    for (int i = 0; i < 3; i++) issue_cmd(2'b10, 12'h400 + 12'(i), 8'hC0 + 8'(i));
    check("mid_in_issue", {30'b0, arb_bus.enable}, 32'd2);
    reset = 1'b1;
    exp_req_q.delete();
    tick(1);
    reset = 1'b0;
    check("mid_rst_en", {30'b0, arb_bus.enable}, 32'd0);
    check("mid_rst_idle", {31'b0, idle}, 32'd1);
    man_ready   = 1'b1;
    man_rd_data = 8'h99;
    tick(1);
    check("mid_no_rd_valid", {31'b0, core_bus.core_rd_valid}, 32'd0);
    tick(1);
    man_ready = 1'b0;
    check("mid_no_rd_valid2", {31'b0, core_bus.core_rd_valid}, 32'd0);
    tick(2);
    check("mid_stays_idle", {31'b0, idle}, 32'd1);
    check("mid_en_zero", {30'b0, arb_bus.enable}, 32'd0);

`ifdef MEM_REQ_TIMEOUT_EN
    // Watchdog: set after TIMEOUT_CYCLES cycles in ISSUE, sticky until reset
    issue_cmd(2'b10, 12'h0FF, 8'h42);
    wait_enable();
    tick(TIMEOUT_CYCLES - 1);
    check("tmo_not_yet", {31'b0, timeout_err}, 32'd0);
    tick(1);
    check("tmo_set", {31'b0, timeout_err}, 32'd1);
    check("tmo_still_waiting", {30'b0, arb_bus.enable}, 32'd2);
    man_ready = 1'b1;
    tick(1);
    man_ready = 1'b0;
    tick(2);
    check("tmo_sticky", {31'b0, timeout_err}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("tmo_cleared", {31'b0, timeout_err}, 32'd0);
`endif

    // Random traffic against the arbitrator model
    auto_arb = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b01 || op == 2'b10) begin
        issue_cmd(op, ADDR_SIZE'($urandom_range(0, 4095)), REG_SIZE'($urandom_range(0, 255)));
      end else begin
        core_bus.core_valid = 1'b1;
        core_bus.core_op    = op;
        tick(1);
        core_bus.core_valid = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) tick(1);
    end
    n = 0;
    while (!(idle && exp_rd_q.size() == 0) && n < 400) begin
      tick(1);
      n++;
    end
    tick(3);
    auto_arb = 1'b0;
    check("rand_idle", {31'b0, idle}, 32'd1);
    check("rand_req_q_empty", 32'(exp_req_q.size()), 32'd0);
    check("rand_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    check("final_timeout", {31'b0, timeout_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
Per-core memory request front end, placed directly upstream of the banked-memory arbitrator. There is one instance per core. It accepts load/store commands from the core pipeline and buffers them in a small in-order FIFO. It presents one request at a time on the core's arbitrator slice (enable/addr/wr_data), holds it until the arbitrator's ready, then returns load data to the core. Stores are posted. Loads stall the core until their data returns.

Parameters:
REG_SIZE, 8, data width and width of in-bank address.
BANK_ID_SIZE, 4, bank select bits; ADDR_SIZE = BANK_ID_SIZE + REG_SIZE, with bank in the MSBs.
FIFO_DEPTH, 4, request queue entries; power of two, at least 2.
TIMEOUT_CYCLES, 255, watchdog limit, used only with MEM_REQ_TIMEOUT_EN.

Ports:
clk  in  1  clock; single clock domain.
reset  in  1  synchronous, active-high reset.
core_valid  in  1  core presents a command this cycle.
core_op  in  2  2'b01 read, 2'b10 write; 2'b00/2'b11 are ignored and never enqueued.
core_addr  in  ADDR_SIZE  {bank, in-bank address}.
core_wr_data  in  REG_SIZE  store data.
core_stall  out  1  command not accepted this cycle; core holds its inputs.
core_rd_valid  out  1  one-cycle pulse; core_rd_data is valid.
core_rd_data  out  REG_SIZE  load result; holds its value until the next load returns.
enable  out  2  {write, read} to the arbitrator; registered.
addr  out  ADDR_SIZE  request address to the arbitrator; registered.
wr_data  out  REG_SIZE  request write data to the arbitrator; registered.
ready  in  1  this core's bit of the arbitrator ready bus.
rd_data  in  REG_SIZE  this core's slice of the arbitrator rd_data bus; valid when ready=1 for a read.
idle  out  1  FIFO empty and FSM in IDLE.
timeout_err  out  1  sticky watchdog flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset values: enable=2'b00, addr=0, wr_data=0, core_rd_valid=0, core_rd_data=0, timeout_err=0, idle=1. FIFO is empty and the FSM is in IDLE.
- Reset mid-operation: the in-flight request and all queued entries are dropped. Any load data arriving in the reset cycle is discarded.
- Accept rule: a command is accepted when core_valid=1, core_op is legal and core_stall=0. It is pushed at the clock edge.
- core_stall (combinational) = FIFO full, OR a read is queued or in flight and not yet returned.
- An illegal core_op never stalls the core and is not enqueued.
- Ordering: strict FIFO order. A load is never issued before older stores.
- FSM states:
  - IDLE: enable=00. If the FIFO is non-empty, the next edge loads the head into enable/addr/wr_data and moves to ISSUE.
  - ISSUE: outputs held stable. On ready=1, the head is popped. If the popped entry is a read, rd_data is captured into core_rd_data and core_rd_valid pulses on the next cycle. The next edge goes to GAP with enable=00.
  - GAP: enable=00 for exactly one cycle and ready is ignored. The next edge goes to ISSUE with the new head if the FIFO is non-empty, otherwise to IDLE.
- Why GAP exists: the arbitrator's ready lags its grant by one cycle, so a request still held in the ready cycle may be granted a second time. That duplicate access repeats an identical read or write, so it is harmless. Its spurious ready falls in GAP and is dropped.
- Minimum spacing: a new request issues no sooner than 3 cycles after the previous one.
- A ready seen while in IDLE is ignored.
- Simultaneous push and pop in the same cycle is legal. The FIFO count is unchanged; full/empty flags use a count of width log2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.
- A push when full cannot occur, because core_stall prevents it.
- Load latency (core_valid to core_rd_valid) with an empty FIFO and uncontended arbitration is 4 cycles:
  - accept edge;
  - IDLE to ISSUE edge;
  - grant edge;
  - ready cycle capture, then core_rd_valid.

Optional Feature:
MEM_REQ_TIMEOUT_EN:
- Defined: a counter clears on entry to ISSUE and increments each cycle spent in ISSUE. When it reaches TIMEOUT_CYCLES without ready, timeout_err is set and stays set until reset. The FSM keeps waiting; the request is not abandoned.
- Undefined: no counter logic; timeout_err is constant 0.

Test Plan:
- Reset then idle: after reset, enable=00, idle=1, core_stall=0, core_rd_valid=0.
- Single store: core_valid=1, op=10, addr=0x305, data=0xA5 → next cycle idle=0; the following cycle enable=10, addr=0x305, wr_data=0xA5. Enable is held until ready=1, then 00 for one cycle; idle=1 afterwards.
- Single load: op=01, addr=0x012; ready driven the cycle after enable=01, with rd_data=0x3C → core_rd_valid pulses next cycle with core_rd_data=0x3C; core_stall=1 from the accept edge until that pulse.
- Queue full and ordering: four stores 0x10..0x13 pushed back-to-back with ready held low → core_stall=1 after the fourth. Then ready pulses once per issue → issue order 0x10..0x13, each separated by a GAP cycle. A ready asserted in GAP does not pop an entry.
- Store then load: a store followed by a load → the load's enable=01 appears only after the store's ready plus GAP; the load data returns correctly.
- Reset mid-request: reset asserted in ISSUE with 2 entries queued → next cycle enable=00, idle=1. A later ready with no request queued produces no pop and no core_rd_valid. With MEM_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, holding ready low sets timeout_err after 8 ISSUE cycles.
